// File: rtl/dma_mux_pkg.sv
// Shared definitions for the DMA read data mux: target encoding and FIFO pointer sizing.
package dma_mux_pkg;

   typedef enum logic {
      TGT_CU = 1'b0,
      TGT_RE = 1'b1
   } tgt_e;

   // Pointer width is one bit wider than the address so full and empty differ.
   function automatic int unsigned fifo_ptr_w(input int unsigned depth);
      int unsigned aw;
      aw = 32'd0;
      for (int unsigned i = 32'd0; i < 32'd32; i++) begin
         if ((32'd1 << i) < depth) begin
            aw = i + 32'd1;
         end else begin
            aw = aw;
         end
      end
      return aw + 32'd1;
   endfunction

endpackage

// File: rtl/dma_rd_route_fifo.sv
// One-bit-wide synchronous FIFO used for descriptor tags and per-segment response routing.
module dma_rd_route_fifo
   import dma_mux_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  logic push_data_i,
   input  logic pop_i,
   output logic pop_data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned PW = fifo_ptr_w(DEPTH);
   localparam int unsigned AW = PW - 32'd1;

   logic [DEPTH-1:0] mem_q;
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW-1:0]    rd_ptr_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty_o    = (wr_ptr_q == rd_ptr_q);
   assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop_s   = pop_i && !empty_o;
   // A pop in the same cycle frees the slot, so a push on full is still taken.
   assign do_push_s  = push_i && (!full_o || do_pop_s);
   assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1'b1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1'b1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
   end

endmodule

// File: rtl/dma_rd_data_mux.sv
// Routes DMA RAM reads to the CU or RE RAM by snooped descriptor tag, returning responses in order.
// Optional command statistics are built when DMA_RD_MUX_STATS_EN is defined.
module dma_rd_data_mux
   import dma_mux_pkg::*;
#(
   parameter int unsigned RAM_SEG_COUNT      = 2,
   parameter int unsigned RAM_SEG_DATA_WIDTH = 256,
   parameter int unsigned RAM_SEG_ADDR_WIDTH = 10,
   parameter int unsigned TAG_FIFO_DEPTH     = 32,
   parameter int unsigned MAX_OUTSTANDING    = 16
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [RAM_SEG_COUNT*RAM_SEG_ADDR_WIDTH-1:0]   dma_ram_rd_cmd_addr,
   input  logic [RAM_SEG_COUNT-1:0]                      dma_ram_rd_cmd_valid,
   output logic [RAM_SEG_COUNT-1:0]                      dma_ram_rd_cmd_ready,
   output logic [RAM_SEG_COUNT*RAM_SEG_DATA_WIDTH-1:0]   dma_ram_rd_resp_data,
   output logic [RAM_SEG_COUNT-1:0]                      dma_ram_rd_resp_valid,
   input  logic [RAM_SEG_COUNT-1:0]                      dma_ram_rd_resp_ready,
   output logic [RAM_SEG_COUNT*RAM_SEG_ADDR_WIDTH-1:0]   cu_dma_ram_rd_cmd_addr,
   output logic [RAM_SEG_COUNT-1:0]                      cu_dma_ram_rd_cmd_valid,
   input  logic [RAM_SEG_COUNT-1:0]                      cu_dma_ram_rd_cmd_ready,
   input  logic [RAM_SEG_COUNT*RAM_SEG_DATA_WIDTH-1:0]   cu_dma_ram_rd_resp_data,
   input  logic [RAM_SEG_COUNT-1:0]                      cu_dma_ram_rd_resp_valid,
   output logic [RAM_SEG_COUNT-1:0]                      cu_dma_ram_rd_resp_ready,
   output logic [RAM_SEG_COUNT*RAM_SEG_ADDR_WIDTH-1:0]   re_dma_ram_rd_cmd_addr,
   output logic [RAM_SEG_COUNT-1:0]                      re_dma_ram_rd_cmd_valid,
   input  logic [RAM_SEG_COUNT-1:0]                      re_dma_ram_rd_cmd_ready,
   input  logic [RAM_SEG_COUNT*RAM_SEG_DATA_WIDTH-1:0]   re_dma_ram_rd_resp_data,
   input  logic [RAM_SEG_COUNT-1:0]                      re_dma_ram_rd_resp_valid,
   output logic [RAM_SEG_COUNT-1:0]                      re_dma_ram_rd_resp_ready,
   input  logic                                          s_axis_dma_write_desc_tag,
   input  logic                                          s_axis_dma_write_desc_valid,
   input  logic                                          s_axis_dma_write_desc_ready,
   input  logic                                          s_axis_dma_write_desc_status_valid,
   output logic                                          err_tag_overflow,
   output logic [31:0]                                   stat_cu_cmd_count,
   output logic [31:0]                                   stat_re_cmd_count
);

   localparam int unsigned AW = RAM_SEG_ADDR_WIDTH;
   localparam int unsigned DW = RAM_SEG_DATA_WIDTH;

   logic                     tag_push_s;
   logic                     tag_head_s;
   logic                     tag_full_s;
   logic                     tag_empty_s;
   logic                     tag_ovf_s;
   tgt_e                     head_tgt_s;
   logic                     err_q;
   logic                     err_d;
   logic [RAM_SEG_COUNT-1:0] cmd_hs_s;
   logic [RAM_SEG_COUNT-1:0] resp_hs_s;

   assign tag_push_s = s_axis_dma_write_desc_valid && s_axis_dma_write_desc_ready;
   assign tag_ovf_s  = tag_push_s && tag_full_s && !(s_axis_dma_write_desc_status_valid && !tag_empty_s);
   assign head_tgt_s = tgt_e'(tag_head_s);

   dma_rd_route_fifo #(
      .DEPTH       (TAG_FIFO_DEPTH)
   ) u_tag_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (tag_push_s),
      .push_data_i (s_axis_dma_write_desc_tag),
      .pop_i       (s_axis_dma_write_desc_status_valid),
      .pop_data_o  (tag_head_s),
      .full_o      (tag_full_s),
      .empty_o     (tag_empty_s)
   );

   for (genvar i = 0; i < RAM_SEG_COUNT; i++) begin : g_seg
      logic rt_head_s;
      logic rt_full_s;
      logic rt_empty_s;
      logic cmd_en_s;
      logic sel_cu_s;
      logic sel_re_s;
      logic rt_cu_s;
      logic rt_re_s;

      // A command may only pass when a target is known and its route slot is free.
      assign cmd_en_s = !tag_empty_s && !rt_full_s;
      assign sel_cu_s = !tag_empty_s && (head_tgt_s == TGT_CU);
      assign sel_re_s = !tag_empty_s && (head_tgt_s == TGT_RE);

      assign dma_ram_rd_cmd_ready[i]    = cmd_en_s && (sel_re_s ? re_dma_ram_rd_cmd_ready[i]
                                                                : cu_dma_ram_rd_cmd_ready[i]);
      assign cu_dma_ram_rd_cmd_valid[i] = cmd_en_s && sel_cu_s && dma_ram_rd_cmd_valid[i];
      assign re_dma_ram_rd_cmd_valid[i] = cmd_en_s && sel_re_s && dma_ram_rd_cmd_valid[i];
      assign cu_dma_ram_rd_cmd_addr[i*AW +: AW] = sel_cu_s ? dma_ram_rd_cmd_addr[i*AW +: AW] : {AW{1'b0}};
      assign re_dma_ram_rd_cmd_addr[i*AW +: AW] = sel_re_s ? dma_ram_rd_cmd_addr[i*AW +: AW] : {AW{1'b0}};
      assign cmd_hs_s[i] = dma_ram_rd_cmd_valid[i] && dma_ram_rd_cmd_ready[i];

      dma_rd_route_fifo #(
         .DEPTH       (MAX_OUTSTANDING)
      ) u_route_fifo (
         .clk         (clk),
         .rst         (rst),
         .push_i      (cmd_hs_s[i]),
         .push_data_i (tag_head_s),
         .pop_i       (resp_hs_s[i]),
         .pop_data_o  (rt_head_s),
         .full_o      (rt_full_s),
         .empty_o     (rt_empty_s)
      );

      assign rt_cu_s = !rt_empty_s && (tgt_e'(rt_head_s) == TGT_CU);
      assign rt_re_s = !rt_empty_s && (tgt_e'(rt_head_s) == TGT_RE);

      assign dma_ram_rd_resp_valid[i] = (rt_cu_s && cu_dma_ram_rd_resp_valid[i]) ||
                                        (rt_re_s && re_dma_ram_rd_resp_valid[i]);
      assign dma_ram_rd_resp_data[i*DW +: DW] = rt_re_s ? re_dma_ram_rd_resp_data[i*DW +: DW] :
                                                rt_cu_s ? cu_dma_ram_rd_resp_data[i*DW +: DW] :
                                                          {DW{1'b0}};
      assign cu_dma_ram_rd_resp_ready[i] = rt_cu_s && dma_ram_rd_resp_ready[i];
      assign re_dma_ram_rd_resp_ready[i] = rt_re_s && dma_ram_rd_resp_ready[i];
      assign resp_hs_s[i] = dma_ram_rd_resp_valid[i] && dma_ram_rd_resp_ready[i];
   end

   always_comb begin
      err_d = err_q;
      if (tag_ovf_s) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_tag_overflow = err_q;

`ifdef DMA_RD_MUX_STATS_EN
   logic [31:0] cu_cnt_q;
   logic [31:0] cu_cnt_d;
   logic [31:0] re_cnt_q;
   logic [31:0] re_cnt_d;

   // One count per cycle with any command handshake, regardless of how many segments fired.
   always_comb begin
      cu_cnt_d = cu_cnt_q;
      re_cnt_d = re_cnt_q;
      if (|cmd_hs_s) begin
         if (head_tgt_s == TGT_RE) begin
            re_cnt_d = re_cnt_q + 32'd1;
         end else begin
            cu_cnt_d = cu_cnt_q + 32'd1;
         end
      end else begin
         cu_cnt_d = cu_cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cu_cnt_q <= 32'd0;
         re_cnt_q <= 32'd0;
      end else begin
         cu_cnt_q <= cu_cnt_d;
         re_cnt_q <= re_cnt_d;
      end
   end

   assign stat_cu_cmd_count = cu_cnt_q;
   assign stat_re_cmd_count = re_cnt_q;
`else
   assign stat_cu_cmd_count = 32'd0;
   assign stat_re_cmd_count = 32'd0;
`endif

endmodule

// File: tb/tb_dma_rd_data_mux.sv
// Scoreboard bench for dma_rd_data_mux with behavioural CU/RE RAM targets.
`timescale 1ns/1ps
module tb_dma_rd_data_mux;

   localparam int SEG = 2;
   localparam int DW  = 32;
   localparam int AW  = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [SEG*AW-1:0] dma_cmd_addr;
   logic [SEG-1:0]    dma_cmd_valid;
   logic [SEG-1:0]    dma_cmd_ready;
   logic [SEG*DW-1:0] dma_resp_data;
   logic [SEG-1:0]    dma_resp_valid;
   logic [SEG-1:0]    dma_resp_ready;
   logic [SEG*AW-1:0] cu_cmd_addr, re_cmd_addr;
   logic [SEG-1:0]    cu_cmd_valid, re_cmd_valid;
   logic [SEG-1:0]    cu_cmd_ready, re_cmd_ready;
   logic [SEG*DW-1:0] cu_resp_data, re_resp_data;
   logic [SEG-1:0]    cu_resp_valid, re_resp_valid;
   logic [SEG-1:0]    cu_resp_ready, re_resp_ready;
   logic              desc_tag, desc_valid, desc_ready, status_valid;
   logic              err_ovf;
   logic [31:0]       stat_cu, stat_re;

   int n_checks = 0;
   int n_fail   = 0;

   dma_rd_data_mux #(
      .RAM_SEG_COUNT      (SEG),
      .RAM_SEG_DATA_WIDTH (DW),
      .RAM_SEG_ADDR_WIDTH (AW),
      .TAG_FIFO_DEPTH     (32),
      .MAX_OUTSTANDING    (16)
   ) dut (
      .clk                                (clk),
      .rst                                (rst),
      .dma_ram_rd_cmd_addr                (dma_cmd_addr),
      .dma_ram_rd_cmd_valid               (dma_cmd_valid),
      .dma_ram_rd_cmd_ready               (dma_cmd_ready),
      .dma_ram_rd_resp_data               (dma_resp_data),
      .dma_ram_rd_resp_valid              (dma_resp_valid),
      .dma_ram_rd_resp_ready              (dma_resp_ready),
      .cu_dma_ram_rd_cmd_addr             (cu_cmd_addr),
      .cu_dma_ram_rd_cmd_valid            (cu_cmd_valid),
      .cu_dma_ram_rd_cmd_ready            (cu_cmd_ready),
      .cu_dma_ram_rd_resp_data            (cu_resp_data),
      .cu_dma_ram_rd_resp_valid           (cu_resp_valid),
      .cu_dma_ram_rd_resp_ready           (cu_resp_ready),
      .re_dma_ram_rd_cmd_addr             (re_cmd_addr),
      .re_dma_ram_rd_cmd_valid            (re_cmd_valid),
      .re_dma_ram_rd_cmd_ready            (re_cmd_ready),
      .re_dma_ram_rd_resp_data            (re_resp_data),
      .re_dma_ram_rd_resp_valid           (re_resp_valid),
      .re_dma_ram_rd_resp_ready           (re_resp_ready),
      .s_axis_dma_write_desc_tag          (desc_tag),
      .s_axis_dma_write_desc_valid        (desc_valid),
      .s_axis_dma_write_desc_ready        (desc_ready),
      .s_axis_dma_write_desc_status_valid (status_valid),
      .err_tag_overflow                   (err_ovf),
      .stat_cu_cmd_count                  (stat_cu),
      .stat_re_cmd_count                  (stat_re)
   );

   function automatic logic [DW-1:0] rdata(input logic t, input logic [AW-1:0] a);
      return {(t ? 8'hEE : 8'hC0), 14'h0000, a};
   endfunction

   // Target RAM models: queue k = tgt*2 + seg, response valid gated by resp_en[k].
   logic [AW-1:0] tq [4][$];
   logic [3:0]    resp_en;
   logic          tb_flush;
   logic [3:0]    rv_q;
   logic [DW-1:0] rd_q [4];

   always @(posedge clk) begin
      for (int s = 0; s < SEG; s++) begin
         if (cu_cmd_valid[s] && cu_cmd_ready[s]) tq[s].push_back(cu_cmd_addr[s*AW +: AW]);
         if (re_cmd_valid[s] && re_cmd_ready[s]) tq[2+s].push_back(re_cmd_addr[s*AW +: AW]);
         if (cu_resp_valid[s] && cu_resp_ready[s]) tq[s].delete(0);
         if (re_resp_valid[s] && re_resp_ready[s]) tq[2+s].delete(0);
      end
      for (int k = 0; k < 4; k++) begin
         if (tb_flush) tq[k].delete();
         if (tq[k].size() != 0 && resp_en[k]) begin
            rv_q[k] <= 1'b1;
            rd_q[k] <= rdata((k >= 2) ? 1'b1 : 1'b0, tq[k][0]);
         end else begin
            rv_q[k] <= 1'b0;
            rd_q[k] <= 32'h0;
         end
      end
   end

   assign cu_resp_valid = rv_q[1:0];
   assign re_resp_valid = rv_q[3:2];
   assign cu_resp_data  = {rd_q[1], rd_q[0]};
   assign re_resp_data  = {rd_q[3], rd_q[2]};

   logic [DW-1:0] exp_q [SEG][$];
   logic [DW-1:0] obs_q [SEG][$];

   always @(negedge clk) begin
      if (!rst) begin
         for (int s = 0; s < SEG; s++) begin
            if (dma_resp_valid[s] && dma_resp_ready[s]) obs_q[s].push_back(dma_resp_data[s*DW +: DW]);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running required=finished");
      $fatal(1, "global timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_tag(input logic t);
      desc_tag = t; desc_valid = 1'b1; desc_ready = 1'b1;
      tick();
      desc_valid = 1'b0; desc_ready = 1'b0;
   endtask

   task automatic pop_tag();
      status_valid = 1'b1;
      tick();
      status_valid = 1'b0;
   endtask

   task automatic issue(input int s, input logic [AW-1:0] a, input logic t);
      int budget = 50;
      logic [AW-1:0] sel_addr, oth_addr;
      logic sel_v, oth_v;
      dma_cmd_addr[s*AW +: AW] = a;
      dma_cmd_valid[s] = 1'b1;
      @(negedge clk);
      while (!dma_cmd_ready[s] && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      n_checks++;
      if (!dma_cmd_ready[s]) begin
         n_fail++;
         $display("FAIL issue_timeout seg=%0d addr=%h ready=0 required=1", s, a);
      end else begin
         exp_q[s].push_back(rdata(t, a));
         sel_v    = t ? re_cmd_valid[s] : cu_cmd_valid[s];
         oth_v    = t ? cu_cmd_valid[s] : re_cmd_valid[s];
         sel_addr = t ? re_cmd_addr[s*AW +: AW] : cu_cmd_addr[s*AW +: AW];
         oth_addr = t ? cu_cmd_addr[s*AW +: AW] : re_cmd_addr[s*AW +: AW];
         n_checks++;
         if ({sel_v, oth_v, sel_addr, oth_addr} !== {1'b1, 1'b0, a, 10'h000}) begin
            n_fail++;
            $display("FAIL cmd_route seg=%0d tgt=%0d got v=%b/%b a=%h/%h required v=1/0 a=%h/000",
                     s, t, sel_v, oth_v, sel_addr, oth_addr, a);
         end
      end
      @(posedge clk);
      #1;
      dma_cmd_valid[s] = 1'b0;
   endtask

   task automatic drain(input int s, input int n);
      int budget = 300;
      logic [DW-1:0] e, o;
      while (obs_q[s].size() < n && budget > 0) begin
         tick();
         budget--;
      end
      n_checks++;
      if (obs_q[s].size() != n || exp_q[s].size() != n) begin
         n_fail++;
         $display("FAIL resp_count seg=%0d observed=%0d expected_q=%0d required=%0d",
                  s, obs_q[s].size(), exp_q[s].size(), n);
      end
      while (obs_q[s].size() > 0 && exp_q[s].size() > 0) begin
         e = exp_q[s].pop_front();
         o = obs_q[s].pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL resp_data seg=%0d got=%h required=%h", s, o, e);
         end
      end
      exp_q[s].delete();
      obs_q[s].delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      dma_cmd_valid = 2'b00; dma_cmd_addr = '0; dma_resp_ready = 2'b11;
      cu_cmd_ready = 2'b11; re_cmd_ready = 2'b11; resp_en = 4'b1111; tb_flush = 1'b0;
      desc_tag = 1'b0; desc_valid = 1'b0; desc_ready = 1'b0; status_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      dma_cmd_valid = 2'b11;
      tick();
      n_checks++;
      if ({dma_cmd_ready, cu_cmd_valid, re_cmd_valid, dma_resp_valid, cu_resp_ready, re_resp_ready} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_handshakes got=%b_%b_%b_%b_%b_%b required=all zero",
                  dma_cmd_ready, cu_cmd_valid, re_cmd_valid, dma_resp_valid, cu_resp_ready, re_resp_ready);
      end
      n_checks++;
      if ({err_ovf, stat_cu, stat_re} !== 65'h0) begin
         n_fail++;
         $display("FAIL reset_status got err=%b cu=%0d re=%0d required 0/0/0", err_ovf, stat_cu, stat_re);
      end
      desc_valid = 1'b1; desc_ready = 1'b0;
      tick();
      desc_valid = 1'b0;
      tick();
      n_checks++;
      if (dma_cmd_ready !== 2'b00) begin
         n_fail++;
         $display("FAIL no_push_without_ready got=%b required=00", dma_cmd_ready);
      end
      dma_cmd_valid = 2'b00;
   endtask

   task automatic test_cu_basic();
      push_tag(1'b0);
      cu_cmd_ready[0] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (dma_cmd_ready[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_follows_target got=%b required=0", dma_cmd_ready[0]);
      end
      tick();
      cu_cmd_ready[0] = 1'b1;
      for (int i = 0; i < 4; i++) issue(0, 10'h010 + 10'(i), 1'b0);
      drain(0, 4);
      pop_tag();
   endtask

   task automatic test_target_switch();
      resp_en = 4'b1100;
      push_tag(1'b0);
      for (int i = 0; i < 4; i++) issue(0, 10'h020 + 10'(i), 1'b0);
      pop_tag();
      push_tag(1'b1);
      @(negedge clk);
      n_checks++;
      if (dma_cmd_ready[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL switch_ready_immediate got=%b required=1", dma_cmd_ready[0]);
      end
      tick();
      for (int i = 0; i < 4; i++) issue(0, 10'h030 + 10'(i), 1'b1);
      repeat (20) tick();
      n_checks++;
      if (obs_q[0].size() != 0) begin
         n_fail++;
         $display("FAIL resp_before_cu got=%0d responses required=0", obs_q[0].size());
      end
      resp_en = 4'b1111;
      drain(0, 8);
      pop_tag();
   endtask

   task automatic test_outstanding();
      dma_resp_ready[1] = 1'b0;
      push_tag(1'b0);
      for (int i = 0; i < 16; i++) issue(1, 10'h100 + 10'(i), 1'b0);
      dma_cmd_addr[AW +: AW] = 10'h110;
      dma_cmd_valid[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({dma_cmd_ready[1], dma_cmd_ready[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL full_route_ready cyc=%0d got seg1=%b seg0=%b required seg1=0 seg0=1",
                     i, dma_cmd_ready[1], dma_cmd_ready[0]);
         end
         tick();
      end
      dma_resp_ready[1] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (dma_resp_valid[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL first_resp_valid got=%b required=1", dma_resp_valid[1]);
      end
      tick();
      dma_resp_ready[1] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (dma_cmd_ready[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_resp got=%b required=1", dma_cmd_ready[1]);
      end else begin
         exp_q[1].push_back(rdata(1'b0, 10'h110));
      end
      tick();
      dma_cmd_valid[1] = 1'b0;
      dma_resp_ready[1] = 1'b1;
      drain(1, 17);
      pop_tag();
   endtask

   task automatic test_tag_overflow();
      for (int i = 0; i < 33; i++) begin
         desc_tag = i[0]; desc_valid = 1'b1; desc_ready = 1'b1;
         tick();
         if (i == 31) begin
            n_checks++;
            if (err_ovf !== 1'b0) begin
               n_fail++;
               $display("FAIL ovf_early got=%b required=0", err_ovf);
            end
         end
      end
      n_checks++;
      if (err_ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_set got=%b required=1", err_ovf);
      end
      desc_tag = 1'b0; status_valid = 1'b1;
      tick();
      desc_valid = 1'b0; desc_ready = 1'b0; status_valid = 1'b0;
      cu_cmd_ready = 2'b00;
      @(negedge clk);
      n_checks++;
      if ({err_ovf, dma_cmd_ready[0]} !== 2'b11) begin
         n_fail++;
         $display("FAIL head_after_pop got err=%b ready=%b required 1/1 (head RE)", err_ovf, dma_cmd_ready[0]);
      end
      tick();
      cu_cmd_ready = 2'b11;
      for (int i = 0; i < 31; i++) pop_tag();
      n_checks++;
      if (dma_cmd_ready[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL fifo_holds_32 got ready=%b required=1 after 31 pops", dma_cmd_ready[0]);
      end
      pop_tag();
      n_checks++;
      if (dma_cmd_ready[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL fifo_empty_after_32 got ready=%b required=0", dma_cmd_ready[0]);
      end
      pop_tag();
   endtask

   task automatic test_stats();
      logic [31:0] exp_cu, exp_re;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      push_tag(1'b0);
      for (int i = 0; i < 5; i++) issue(i % 2, 10'h200 + 10'(i), 1'b0);
      pop_tag();
      push_tag(1'b1);
      for (int i = 0; i < 7; i++) issue(i % 2, 10'h280 + 10'(i), 1'b1);
      pop_tag();
      drain(0, 7);
      drain(1, 5);
`ifdef DMA_RD_MUX_STATS_EN
      exp_cu = 32'd5; exp_re = 32'd7;
`else
      exp_cu = 32'd0; exp_re = 32'd0;
`endif
      n_checks++;
      if ({stat_cu, stat_re} !== {exp_cu, exp_re}) begin
         n_fail++;
         $display("FAIL stats got cu=%0d re=%0d required cu=%0d re=%0d", stat_cu, stat_re, exp_cu, exp_re);
      end
   endtask

   task automatic test_reset_midop();
      resp_en = 4'b0000;
      push_tag(1'b0);
      for (int i = 0; i < 3; i++) issue(0, 10'h300 + 10'(i), 1'b0);
      exp_q[0].delete();
      dma_cmd_valid = 2'b11;
      rst = 1'b1;
      tick();
      n_checks++;
      if ({dma_cmd_ready, cu_cmd_valid, re_cmd_valid, dma_resp_valid, cu_resp_ready, re_resp_ready, err_ovf} !== 13'h0) begin
         n_fail++;
         $display("FAIL midop_reset_outputs got=%b_%b_%b_%b_%b_%b err=%b required=all zero",
                  dma_cmd_ready, cu_cmd_valid, re_cmd_valid, dma_resp_valid, cu_resp_ready, re_resp_ready, err_ovf);
      end
      rst = 1'b0;
      dma_cmd_valid = 2'b00;
      resp_en = 4'b1111;
      repeat (10) tick();
      n_checks++;
      if (obs_q[0].size() != 0 || dma_resp_valid !== 2'b00) begin
         n_fail++;
         $display("FAIL stale_resp_forwarded got=%0d resp_valid=%b required=0/00", obs_q[0].size(), dma_resp_valid);
      end
      tb_flush = 1'b1;
      tick();
      tb_flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_cu_basic();
      test_target_switch();
      test_outstanding();
      test_tag_overflow();
      test_stats();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
